// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered sequential ALU with a Start/Busy/Done handshake, a
//            carry register and two multi-cycle ops (popcount, shift-add
//            multiply). Results and branch/jump flags are held until the next
//            operation completes.
// Ports    : clk    - clock, rising edge
//            reset  - asynchronous, active-low reset
//            Start  - operation request, sampled only when not Busy
//            Aluop  - 4-bit opcode, captured with Start
//            Imm    - IMM_W-bit two's complement immediate, captured with Start
//            DatA   - operand A, captured with Start
//            DatB   - operand B, captured with Start
//            Busy   - multi-cycle op in progress
//            Done   - one-cycle pulse; Rslt/flags updated in that cycle
//            Rslt   - registered result
//            Zero   - Rslt == 0
//            Par    - XOR reduction of Rslt
//            Jen    - registered jump enable
//            Brc_J  - registered branch-not-taken flag
//            Carry  - carry/borrow register
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8,  // >= 4
  parameter int IMM_W = 3   // >= 2, and <= WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       Aluop,
  input  logic [IMM_W-1:0] Imm,
  input  logic [WIDTH-1:0] DatA,
  input  logic [WIDTH-1:0] DatB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Rslt,
  output logic             Zero,
  output logic             Par,
  output logic             Jen,
  output logic             Brc_J,
  output logic             Carry
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_XOR     = 4'd0;
  localparam logic [3:0] OP_ADDC    = 4'd1;
  localparam logic [3:0] OP_SUBB    = 4'd2;
  localparam logic [3:0] OP_ISZERO  = 4'd3;
  localparam logic [3:0] OP_SIGNPOS = 4'd4;
  localparam logic [3:0] OP_POPCNT  = 4'd5;
  localparam logic [3:0] OP_BLT     = 4'd6;
  localparam logic [3:0] OP_BEQ     = 4'd7;
  localparam logic [3:0] OP_PASS    = 4'd8;
  localparam logic [3:0] OP_SHIFT   = 4'd9;
  localparam logic [3:0] OP_ADDI    = 4'd10;
  localparam logic [3:0] OP_SUBI    = 4'd11;
  localparam logic [3:0] OP_JMP0    = 4'd12;
  localparam logic [3:0] OP_JMP1    = 4'd13;
  localparam logic [3:0] OP_MUL     = 4'd14;
  localparam logic [3:0] OP_CLRC    = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             op_mul;   // 1: multiply, 0: popcount
  logic [WIDTH-1:0] ma;       // shifting operand A copy
  logic [WIDTH-1:0] mb;       // shifting operand B copy (multiplier)
  logic [WIDTH-1:0] acc;      // partial result
  logic [CNT_W-1:0] cnt;      // remaining bit steps

  // Single-cycle datapath, evaluated on the live inputs at acceptance.
  logic [WIDTH:0]   ext_a;
  logic [WIDTH:0]   ext_b;
  logic [WIDTH:0]   ext_imm;
  logic [WIDTH:0]   ext_cin;
  logic [WIDTH:0]   arith;
  logic [IMM_W:0]   shamt_neg;
  logic [WIDTH-1:0] sc_rslt;
  logic             sc_carry;
  logic             sc_jen;
  logic             sc_brc;
  logic             is_branch;
  logic             is_multi;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    ext_a   = {1'b0, DatA};
    ext_b   = {1'b0, DatB};
    ext_imm = '0;
    ext_imm[IMM_W-1:0] = Imm;
    ext_cin = '0;
    ext_cin[0] = Carry;
    // Magnitude of a negative immediate; one bit wider so the most-negative
    // value maps to 2^(IMM_W-1) instead of wrapping.
    shamt_neg = {1'b0, ~Imm} + (IMM_W+1)'(1);
    arith     = '0;
    sc_rslt   = '0;
    sc_carry  = Carry;
    sc_jen    = 1'b0;
    sc_brc    = 1'b0;
    case (Aluop)
      OP_XOR:     sc_rslt = DatA ^ DatB;
      OP_ADDC: begin
        arith    = ext_a + ext_b + ext_cin;
        sc_rslt  = arith[WIDTH-1:0];
        sc_carry = arith[WIDTH];
      end
      OP_SUBB: begin
        // Top bit of the (WIDTH+1)-bit difference is the borrow.
        arith    = ext_a - ext_b - ext_cin;
        sc_rslt  = arith[WIDTH-1:0];
        sc_carry = arith[WIDTH];
      end
      OP_ISZERO:  sc_rslt = {{(WIDTH-1){1'b0}}, (DatA == '0)};
      OP_SIGNPOS: sc_rslt = {{(WIDTH-1){1'b0}}, ~DatA[WIDTH-1]};
      OP_BLT:     sc_brc  = !(DatA < DatB);
      OP_BEQ:     sc_brc  = (DatA != DatB);
      OP_PASS:    sc_rslt = DatA;
      OP_SHIFT: begin
        if (!Imm[IMM_W-1]) sc_rslt = DatA << Imm;
        else               sc_rslt = DatA >> shamt_neg;
      end
      OP_ADDI: begin
        arith    = ext_a + ext_imm + ext_cin;
        sc_rslt  = arith[WIDTH-1:0];
        sc_carry = arith[WIDTH];
      end
      OP_SUBI: begin
        arith    = ext_a - ext_imm - ext_cin;
        sc_rslt  = arith[WIDTH-1:0];
        sc_carry = arith[WIDTH];
      end
      OP_JMP0, OP_JMP1: sc_jen = 1'b1;
      OP_CLRC: begin
        sc_rslt  = '0;
        sc_carry = 1'b0;
      end
      default:    sc_rslt = '0;
    endcase
  end

  assign is_branch = (Aluop == OP_BLT) || (Aluop == OP_BEQ) ||
                     (Aluop == OP_JMP0) || (Aluop == OP_JMP1);
  assign is_multi  = (Aluop == OP_POPCNT) || (Aluop == OP_MUL);

  // One bit per step: multiply adds the shifted multiplicand when the current
  // multiplier bit is set; popcount adds the current LSB of A.
  always_comb begin
    if (op_mul) acc_nxt = acc + (mb[0] ? ma : '0);
    else        acc_nxt = acc + {{(WIDTH-1){1'b0}}, ma[0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      Rslt   <= '0;
      Jen    <= 1'b0;
      Brc_J  <= 1'b0;
      Carry  <= 1'b0;
      op_mul <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            if (is_multi) begin
              op_mul <= (Aluop == OP_MUL);
              ma     <= DatA;
              mb     <= DatB;
              acc    <= '0;
              cnt    <= CNT_W'(WIDTH);
              state  <= RUN;
            end else begin
              if (is_branch) begin
                Jen   <= sc_jen;
                Brc_J <= sc_brc;
              end else begin
                Rslt  <= sc_rslt;
                Jen   <= 1'b0;
                Brc_J <= 1'b0;
              end
              Carry <= sc_carry;
              state <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          ma  <= op_mul ? (ma << 1) : (ma >> 1);
          mb  <= mb >> 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            Rslt  <= acc_nxt;
            Jen   <= 1'b0;
            Brc_J <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);
  assign Zero = (Rslt == '0);
  assign Par  = ^Rslt;

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU; sits between the register file and the writeback/branch logic of the core.
- Adds configurable data width and immediate width, a Start/Busy/Done handshake, an explicit carry register, and two multi-cycle ops: iterative popcount and shift-add multiply.
- All results and branch/jump flags are registered and held until the next operation completes.

Parameters:
- WIDTH, 8, datapath width in bits (≥4).
- IMM_W, 3, immediate width in bits, two's complement (≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only when Busy=0.
- Aluop  in  4  operation code, captured with Start.
- Imm  in  IMM_W  immediate, captured with Start.
- DatA  in  WIDTH  operand A, captured with Start.
- DatB  in  WIDTH  operand B, captured with Start.
- Busy  out  1  multi-cycle op in progress.
- Done  out  1  one-cycle pulse; Rslt and flags are updated in that cycle.
- Rslt  out  WIDTH  registered result.
- Zero  out  1  Rslt==0, combinational from Rslt.
- Par  out  1  XOR-reduce of Rslt.
- Jen  out  1  registered jump enable.
- Brc_J  out  1  registered branch-not-taken flag (1 = condition false).
- Carry  out  1  carry/borrow register.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; Rslt, Busy, Done, Jen, Brc_J, Carry = 0.
  - Applies immediately, including mid-RUN; a partial result is discarded.
- States IDLE, RUN, DONE.
  - Busy = (state==RUN).
  - Done = (state==DONE).
  - Start is accepted in IDLE or DONE and ignored in RUN.
- Single-cycle ops: Start sampled at edge k → DONE after edge k; Rslt/flags valid that cycle.
- Multi-cycle ops (POPCNT, MUL):
  - Edge k → RUN with counter=WIDTH.
  - One bit per edge; result written and DONE entered after edge k+WIDTH.
- DONE → IDLE on the next edge unless Start is high, in which case the new op is accepted.
- Completion of any op other than branch/jump ops writes Rslt and clears Jen and Brc_J.
- Branch/jump ops hold Rslt and write Jen and Brc_J.
- Carry register:
  - Written only at completion of ADDC/SUBB/ADDI/SUBI.
  - CLRC clears it.
  - All other ops hold it.
- Ops (cin = Carry register):
  - 0 XOR: A^B.
  - 1 ADDC: {c,R}=A+B+cin, computed in WIDTH+1 bits.
  - 2 SUBB: {c,R}=A−B−cin, computed in WIDTH+1 bits; c=1 means borrow.
  - 3 ISZERO: R=1 if A==0, else 0.
  - 4 SIGNPOS: R=~A[WIDTH-1], zero-extended.
  - 5 POPCNT: number of 1s in A; multi-cycle.
  - 6 BLT: Brc_J = !(A<B), unsigned; Jen=0.
  - 7 BEQ: Brc_J = !(A==B); Jen=0.
  - 8 PASS: R=A.
  - 9 SHIFT:
    - Imm ≥ 0: A<<Imm.
    - Imm < 0: logical A>>(−Imm); the most-negative Imm shifts by 2^(IMM_W−1).
  - 10 ADDI: {c,R}=A+zext(Imm)+cin.
  - 11 SUBI: {c,R}=A−zext(Imm)−cin.
  - 12, 13 JMP: Jen=1, Brc_J=0.
  - 14 MUL: low WIDTH bits of unsigned A×B via shift-add; multi-cycle; Carry untouched.
  - 15 CLRC: Carry=0, R=0.
- Operands are latched at acceptance; input changes during RUN have no effect.

Test Plan:
- Reset low then high → Rslt=0, Zero=1, Par=0, Busy=0, Done=0, Carry=0. ADDC 0xFF+0x01 → Done after 1 edge, Rslt=0x00, Carry=1, Zero=1. Next ADDC 0x01+0x01 → Rslt=0x03, Carry=0.
- SUBB 0x00−0x01, Carry=0 → Rslt=0xFF, Carry=1, Par=0. Then PASS 0x5A → Rslt=0x5A, Carry still 1. Then CLRC → Carry=0.
- POPCNT A=0xB5 → Busy high for 8 cycles, Done after edge k+8, Rslt=0x05, Par=0. A Start (XOR) pulsed during RUN is ignored.
- MUL 0x0D×0x0B → Done after edge k+8, Rslt=0x8F, Par=1, Carry unchanged. Back-to-back Start held high in DONE is accepted without an IDLE cycle.
- SHIFT A=0xF0, Imm=3'b101 → 0x1E. SHIFT A=0x81, Imm=3'b011 → 0x08. Imm=3'b100 on 0xF0 → 0x0F.
- BLT 3,5 → Brc_J=0, Jen=0, Rslt held. BEQ 7,8 → Brc_J=1. JMP → Jen=1. MUL started then reset pulled low mid-RUN → Busy=0, Done=0, Rslt=0 immediately, without waiting for an edge.
